// File: rtl/l2_dr_arb.sv
// Arbiter for the shared L2-to-directory link: merges L2 and L2TLB requests through a
// 2-entry output FIFO, routes directory snacks back by nodeid parity, and caps L2TLB credits.
module l2_dr_arb #(
  parameter int NID_W   = 5,
  parameter int L2ID_W  = 6,
  parameter int CMD_W   = 3,
  parameter int PADDR_W = 50,
  parameter int SNP_W   = 530,
  parameter int TLB_MAX = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   l2_req_valid,
  output logic                                   l2_req_retry,
  input  logic [NID_W+L2ID_W+CMD_W+PADDR_W-1:0]  l2_req,
  input  logic                                   tlb_req_valid,
  output logic                                   tlb_req_retry,
  input  logic [NID_W+L2ID_W+CMD_W+PADDR_W-1:0]  tlb_req,
  output logic                                   l2todr_req_valid,
  input  logic                                   l2todr_req_retry,
  output logic [NID_W+L2ID_W+CMD_W+PADDR_W-1:0]  l2todr_req,
  input  logic                                   drtol2_snack_valid,
  output logic                                   drtol2_snack_retry,
  input  logic [NID_W-1:0]                       drtol2_snack_nid,
  input  logic [L2ID_W-1:0]                      drtol2_snack_l2id,
  input  logic [SNP_W-1:0]                       drtol2_snack_data,
  output logic                                   l2_snack_valid,
  input  logic                                   l2_snack_retry,
  output logic                                   tlb_snack_valid,
  input  logic                                   tlb_snack_retry,
  output logic [NID_W-1:0]                       snack_nid,
  output logic [L2ID_W-1:0]                      snack_l2id,
  output logic [SNP_W-1:0]                       snack_data
);

  localparam int REQ_W   = NID_W + L2ID_W + CMD_W + PADDR_W;
  localparam int NID_LSB = REQ_W - NID_W;
  localparam int CRD_W   = $clog2(TLB_MAX + 1);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(TLB_MAX);

  typedef enum logic {SRC_L2 = 1'b0, SRC_TLB = 1'b1} src_e;

  // Credit update saturates at zero so a spurious ack cannot wrap the counter.
  function automatic logic [CRD_W-1:0] credit_next(input logic [CRD_W-1:0] cur,
                                                    input logic inc, input logic dec);
    logic [CRD_W-1:0] r;
    r = cur;
    if (inc && !dec)                     r = cur + CRD_W'(1);
    else if (dec && !inc && cur != '0)   r = cur - CRD_W'(1);
    return r;
  endfunction

  logic [REQ_W-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  src_e             last_q, last_d;
  logic [CRD_W-1:0] tlb_out_q, tlb_out_d;

  logic             space, tlb_ok, grant_l2, grant_tlb, push, pop;
  logic             sel_tlb, tlb_ack;
  logic [REQ_W-1:0] push_data;

  always_comb begin
    space     = (count_q < 2'd2);
    tlb_ok    = tlb_req_valid && (tlb_out_q < CRD_MAX);
    grant_l2  = 1'b0;
    grant_tlb = 1'b0;
    if (space) begin
      if (l2_req_valid && tlb_ok) begin
        if (last_q == SRC_L2) grant_tlb = 1'b1;
        else                  grant_l2  = 1'b1;
      end else if (l2_req_valid) begin
        grant_l2 = 1'b1;
      end else if (tlb_ok) begin
        grant_tlb = 1'b1;
      end
    end
    push = grant_l2 || grant_tlb;
    pop  = (count_q != 2'd0) && !l2todr_req_retry;

    // nid[0] tags the source so the snack demux can return the response.
    push_data          = grant_tlb ? tlb_req : l2_req;
    push_data[NID_LSB] = grant_tlb;
  end

  assign l2_req_retry     = l2_req_valid && !grant_l2;
  assign tlb_req_retry    = tlb_req_valid && !grant_tlb;
  assign l2todr_req_valid = (count_q != 2'd0);
  assign l2todr_req       = mem_q[rd_ptr_q];

  assign sel_tlb            = drtol2_snack_nid[0];
  assign l2_snack_valid     = drtol2_snack_valid && !sel_tlb;
  assign tlb_snack_valid    = drtol2_snack_valid && sel_tlb;
  assign drtol2_snack_retry = sel_tlb ? tlb_snack_retry : l2_snack_retry;
  assign snack_nid          = drtol2_snack_nid;
  assign snack_l2id         = drtol2_snack_l2id;
  assign snack_data         = drtol2_snack_data;

  // Snoops carry l2id==0 and do not retire an outstanding TLB request.
  assign tlb_ack = tlb_snack_valid && !tlb_snack_retry && (drtol2_snack_l2id != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    last_d    = push ? (grant_tlb ? SRC_TLB : SRC_L2) : last_q;
    tlb_out_d = credit_next(tlb_out_q, push && grant_tlb, tlb_ack);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      last_q    <= SRC_TLB;
      tlb_out_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      tlb_out_q <= tlb_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_l2_dr_arb.sv
// Directed bench for l2_dr_arb: arbitration, backpressure, TLB credits, snack routing, reset.
module tb_l2_dr_arb;

  localparam int NID_W = 5, L2ID_W = 6, CMD_W = 3, PADDR_W = 50, SNP_W = 530, TLB_MAX = 4;
  localparam int REQ_W = NID_W + L2ID_W + CMD_W + PADDR_W;

  logic              clk, reset;
  logic              l2_req_valid, l2_req_retry, tlb_req_valid, tlb_req_retry;
  logic [REQ_W-1:0]  l2_req, tlb_req, l2todr_req;
  logic              l2todr_req_valid, l2todr_req_retry;
  logic              drtol2_snack_valid, drtol2_snack_retry;
  logic [NID_W-1:0]  drtol2_snack_nid, snack_nid;
  logic [L2ID_W-1:0] drtol2_snack_l2id, snack_l2id;
  logic [SNP_W-1:0]  drtol2_snack_data, snack_data;
  logic              l2_snack_valid, l2_snack_retry, tlb_snack_valid, tlb_snack_retry;

  int tests_run = 0;
  int fails = 0;

  l2_dr_arb #(.NID_W(NID_W), .L2ID_W(L2ID_W), .CMD_W(CMD_W), .PADDR_W(PADDR_W),
              .SNP_W(SNP_W), .TLB_MAX(TLB_MAX)) dut (
    .clk(clk), .reset(reset),
    .l2_req_valid(l2_req_valid), .l2_req_retry(l2_req_retry), .l2_req(l2_req),
    .tlb_req_valid(tlb_req_valid), .tlb_req_retry(tlb_req_retry), .tlb_req(tlb_req),
    .l2todr_req_valid(l2todr_req_valid), .l2todr_req_retry(l2todr_req_retry),
    .l2todr_req(l2todr_req),
    .drtol2_snack_valid(drtol2_snack_valid), .drtol2_snack_retry(drtol2_snack_retry),
    .drtol2_snack_nid(drtol2_snack_nid), .drtol2_snack_l2id(drtol2_snack_l2id),
    .drtol2_snack_data(drtol2_snack_data),
    .l2_snack_valid(l2_snack_valid), .l2_snack_retry(l2_snack_retry),
    .tlb_snack_valid(tlb_snack_valid), .tlb_snack_retry(tlb_snack_retry),
    .snack_nid(snack_nid), .snack_l2id(snack_l2id), .snack_data(snack_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returning a credit while none is outstanding is a protocol error.
  always @(posedge clk) begin
    if (reset && drtol2_snack_valid && drtol2_snack_nid[0] && !tlb_snack_retry &&
        drtol2_snack_l2id != '0)
      assert (dut.tlb_out_q != '0) else $error("credit underflow on TLB ack");
  end

  function automatic logic [REQ_W-1:0] mk(input logic [NID_W-1:0] nid, input logic [L2ID_W-1:0] id,
                                          input logic [CMD_W-1:0] cmd, input logic [PADDR_W-1:0] pa);
    return {nid, id, cmd, pa};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    l2_req_valid = 1'b0; l2_req = '0; tlb_req_valid = 1'b0; tlb_req = '0;
    l2todr_req_retry = 1'b0; drtol2_snack_valid = 1'b0; drtol2_snack_nid = '0;
    drtol2_snack_l2id = '0; drtol2_snack_data = '0; l2_snack_retry = 1'b0; tlb_snack_retry = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (l2todr_req_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", l2todr_req_valid); end
    tests_run++;
    if (dut.tlb_out_q !== '0) begin fails++; $display("FAIL reset_tlb_out: got %0d want 0", dut.tlb_out_q); end
    tests_run++;
    if (l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b0) begin
      fails++; $display("FAIL reset_retry: got %b%b want 00", l2_req_retry, tlb_req_retry);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [REQ_W-1:0] exp_req;
    exp_req = mk(5'd4, 6'd3, 3'd1, 50'h1000);
    do_reset();
    l2_req_valid = 1'b1; l2_req = exp_req;
    @(negedge clk);
    tests_run++;
    if (l2_req_retry !== 1'b0 || l2todr_req_valid !== 1'b0) begin
      fails++; $display("FAIL single_accept: retry=%b valid=%b want 0 0", l2_req_retry, l2todr_req_valid);
    end
    tick();
    l2_req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (l2todr_req_valid !== 1'b1 || l2todr_req !== exp_req) begin
      fails++; $display("FAIL single_out: valid=%b req=%h want 1 %h", l2todr_req_valid, l2todr_req, exp_req);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (l2todr_req_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b want 0", l2todr_req_valid); end
  endtask

  task automatic test_arbitration();
    logic [REQ_W-1:0] l2p, tlbp, exp_l2, exp_tlb, exp_req;
    l2p = mk(5'd2, 6'd1, 3'd2, 50'hA0);  exp_l2 = l2p;
    tlbp = mk(5'd4, 6'd5, 3'd3, 50'hB0); exp_tlb = mk(5'd5, 6'd5, 3'd3, 50'hB0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      l2_req_valid = 1'b1; l2_req = l2p; tlb_req_valid = 1'b1; tlb_req = tlbp;
      @(negedge clk);
      tests_run++;
      if (l2_req_retry !== logic'(i % 2) || tlb_req_retry !== logic'((i + 1) % 2)) begin
        fails++; $display("FAIL arb_grant[%0d]: retry l2=%b tlb=%b want %0d %0d", i,
                          l2_req_retry, tlb_req_retry, i % 2, (i + 1) % 2);
      end
      if (i > 0) begin
        exp_req = ((i - 1) % 2 == 0) ? exp_l2 : exp_tlb;
        tests_run++;
        if (l2todr_req_valid !== 1'b1 || l2todr_req !== exp_req) begin
          fails++; $display("FAIL arb_out[%0d]: got %b %h want 1 %h", i - 1, l2todr_req_valid, l2todr_req, exp_req);
        end
      end
      tick();
    end
    l2_req_valid = 1'b0; tlb_req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (l2todr_req_valid !== 1'b1 || l2todr_req !== exp_tlb) begin
      fails++; $display("FAIL arb_out[3]: got %b %h want 1 %h", l2todr_req_valid, l2todr_req, exp_tlb);
    end
    tests_run++;
    if (dut.count_q !== 2'd1) begin fails++; $display("FAIL arb_count: got %0d want 1", dut.count_q); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [REQ_W-1:0] p [3];
    for (int k = 0; k < 3; k++) p[k] = mk(5'd6, 6'(k + 1), 3'd1, 50'h3000 + 50'(k));
    do_reset();
    l2todr_req_retry = 1'b1;
    for (int c = 0; c < 5; c++) begin
      l2_req_valid = 1'b1; l2_req = p[(c < 2) ? c : 2];
      @(negedge clk);
      tests_run++;
      if (l2_req_retry !== (c >= 2) || l2todr_req_valid !== (c >= 1)) begin
        fails++; $display("FAIL bp_stall[%0d]: retry=%b valid=%b want %0d %0d", c,
                          l2_req_retry, l2todr_req_valid, c >= 2, c >= 1);
      end
      if (c == 2) begin
        tests_run++;
        if (dut.count_q !== 2'd2) begin fails++; $display("FAIL bp_count: got %0d want 2", dut.count_q); end
      end
      tick();
    end
    l2todr_req_retry = 1'b0;
    @(negedge clk);
    tests_run++;
    if (l2_req_retry !== 1'b1 || l2todr_req !== p[0]) begin
      fails++; $display("FAIL bp_rel0: retry=%b req=%h want 1 %h", l2_req_retry, l2todr_req, p[0]);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (l2_req_retry !== 1'b0 || l2todr_req !== p[1]) begin
      fails++; $display("FAIL bp_rel1: retry=%b req=%h want 0 %h", l2_req_retry, l2todr_req, p[1]);
    end
    tick();
    l2_req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (l2todr_req_valid !== 1'b1 || l2todr_req !== p[2]) begin
      fails++; $display("FAIL bp_rel2: valid=%b req=%h want 1 %h", l2todr_req_valid, l2todr_req, p[2]);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (l2todr_req_valid !== 1'b0) begin fails++; $display("FAIL bp_dup: valid=%b want 0", l2todr_req_valid); end
  endtask

  task automatic test_credit();
    logic [REQ_W-1:0] t [5];
    logic [REQ_W-1:0] tout [5];
    for (int k = 0; k < 5; k++) begin
      t[k]    = mk(5'd2, 6'(k + 1), 3'd4, 50'h2000 + 50'(k));
      tout[k] = mk(5'd3, 6'(k + 1), 3'd4, 50'h2000 + 50'(k));
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tlb_req_valid = 1'b1; tlb_req = t[k];
      @(negedge clk);
      tests_run++;
      if (tlb_req_retry !== 1'b0) begin fails++; $display("FAIL credit_accept[%0d]: retry=%b want 0", k, tlb_req_retry); end
      if (k > 0) begin
        tests_run++;
        if (l2todr_req !== tout[k - 1]) begin
          fails++; $display("FAIL credit_out[%0d]: got %h want %h", k - 1, l2todr_req, tout[k - 1]);
        end
      end
      tick();
    end
    tlb_req = t[4];
    drtol2_snack_valid = 1'b1; drtol2_snack_nid = 5'd5; drtol2_snack_l2id = 6'd2;
    @(negedge clk);
    tests_run++;
    if (tlb_req_retry !== 1'b1 || dut.tlb_out_q !== 3'd4) begin
      fails++; $display("FAIL credit_full: retry=%b tlb_out=%0d want 1 4", tlb_req_retry, dut.tlb_out_q);
    end
    tests_run++;
    if (tlb_snack_valid !== 1'b1 || drtol2_snack_retry !== 1'b0 || l2todr_req !== tout[3]) begin
      fails++; $display("FAIL credit_ack: tsv=%b sretry=%b req=%h want 1 0 %h", tlb_snack_valid,
                        drtol2_snack_retry, l2todr_req, tout[3]);
    end
    tick();
    drtol2_snack_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tlb_req_retry !== 1'b0 || dut.tlb_out_q !== 3'd3 || l2todr_req_valid !== 1'b0) begin
      fails++; $display("FAIL credit_return: retry=%b tlb_out=%0d valid=%b want 0 3 0", tlb_req_retry,
                        dut.tlb_out_q, l2todr_req_valid);
    end
    tick();
    tlb_req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (l2todr_req !== tout[4] || dut.tlb_out_q !== 3'd4) begin
      fails++; $display("FAIL credit_fifth: req=%h tlb_out=%0d want %h 4", l2todr_req, dut.tlb_out_q, tout[4]);
    end
    tick();
  endtask

  task automatic test_snack();
    logic [SNP_W-1:0] d1;
    d1 = '0; d1[SNP_W-1 -: 32] = 32'hA5A5_0001; d1[31:0] = 32'h1234_5678;
    drtol2_snack_valid = 1'b1; drtol2_snack_nid = 5'd6; drtol2_snack_l2id = 6'd3;
    drtol2_snack_data = d1; l2_snack_retry = 1'b0; tlb_snack_retry = 1'b1;
    @(negedge clk);
    tests_run++;
    if (l2_snack_valid !== 1'b1 || tlb_snack_valid !== 1'b0 || drtol2_snack_retry !== 1'b0) begin
      fails++; $display("FAIL snack_even: l2v=%b tlbv=%b retry=%b want 1 0 0", l2_snack_valid,
                        tlb_snack_valid, drtol2_snack_retry);
    end
    tests_run++;
    if (snack_nid !== 5'd6 || snack_l2id !== 6'd3 || snack_data !== d1) begin
      fails++; $display("FAIL snack_payload: nid=%0d l2id=%0d data_lo=%h want 6 3 12345678", snack_nid,
                        snack_l2id, snack_data[31:0]);
    end
    tick();
    l2_snack_retry = 1'b1;
    @(negedge clk);
    tests_run++;
    if (drtol2_snack_retry !== 1'b1) begin fails++; $display("FAIL snack_l2_retry: got %b want 1", drtol2_snack_retry); end
    tick();
    l2_snack_retry = 1'b0; drtol2_snack_nid = 5'd7; drtol2_snack_l2id = 6'd0;
    @(negedge clk);
    tests_run++;
    if (tlb_snack_valid !== 1'b1 || l2_snack_valid !== 1'b0 || drtol2_snack_retry !== 1'b1) begin
      fails++; $display("FAIL snack_odd: tlbv=%b l2v=%b retry=%b want 1 0 1", tlb_snack_valid,
                        l2_snack_valid, drtol2_snack_retry);
    end
    tick();
    tlb_snack_retry = 1'b0;
    @(negedge clk);
    tests_run++;
    if (drtol2_snack_retry !== 1'b0) begin fails++; $display("FAIL snack_tlb_go: got %b want 0", drtol2_snack_retry); end
    tick();
    drtol2_snack_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dut.tlb_out_q !== 3'd4) begin fails++; $display("FAIL snoop_credit: got %0d want 4", dut.tlb_out_q); end
    tick();
    drtol2_snack_valid = 1'b1; drtol2_snack_l2id = 6'd5;
    tick();
    drtol2_snack_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dut.tlb_out_q !== 3'd3) begin fails++; $display("FAIL ack_credit: got %0d want 3", dut.tlb_out_q); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [REQ_W-1:0] lp;
    lp = mk(5'd10, 6'd7, 3'd5, 50'h5000);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      l2todr_req_retry = (c == 2);
      tlb_req_valid = 1'b1; tlb_req = mk(5'd8, 6'(c + 1), 3'd2, 50'h4000 + 50'(c));
      tick();
    end
    tlb_req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dut.count_q !== 2'd2 || dut.tlb_out_q !== 3'd3 || l2todr_req_valid !== 1'b1) begin
      fails++; $display("FAIL mid_setup: count=%0d tlb_out=%0d valid=%b want 2 3 1", dut.count_q,
                        dut.tlb_out_q, l2todr_req_valid);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (l2todr_req_valid !== 1'b0 || dut.count_q !== 2'd0 || dut.tlb_out_q !== '0) begin
      fails++; $display("FAIL mid_reset: valid=%b count=%0d tlb_out=%0d want 0 0 0", l2todr_req_valid,
                        dut.count_q, dut.tlb_out_q);
    end
    tick();
    reset = 1'b1; l2todr_req_retry = 1'b0;
    @(negedge clk);
    tests_run++;
    if (l2todr_req_valid !== 1'b0) begin fails++; $display("FAIL mid_idle: valid=%b want 0", l2todr_req_valid); end
    tick();
    l2_req_valid = 1'b1; l2_req = lp; tlb_req_valid = 1'b1; tlb_req = mk(5'd8, 6'd9, 3'd2, 50'h4100);
    @(negedge clk);
    tests_run++;
    if (l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b1) begin
      fails++; $display("FAIL mid_tie: retry l2=%b tlb=%b want 0 1", l2_req_retry, tlb_req_retry);
    end
    tick();
    l2_req_valid = 1'b0; tlb_req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (l2todr_req !== lp || l2todr_req_valid !== 1'b1) begin
      fails++; $display("FAIL mid_out: valid=%b req=%h want 1 %h", l2todr_req_valid, l2todr_req, lp);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_back_to_back();
    test_credit();
    test_snack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
